// File: rtl/ulpb_rx_buffer_if.sv
// rtl/ulpb_rx_buffer_if.sv - ULPB receive handshake, message stream and oversize flag bundle
interface ulpb_rx_buffer_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] RX_ADDR;
    logic [DATA_WIDTH-1:0] RX_DATA;
    logic                  RX_REQ;
    logic                  RX_PEND;
    logic                  RX_ACK;
    logic [ADDR_WIDTH-1:0] MSG_ADDR;
    logic [DATA_WIDTH-1:0] MSG_DATA;
    logic                  MSG_LAST;
    logic                  MSG_VALID;
    logic                  MSG_READY;
    logic                  OVERSIZE;
    logic                  OVERSIZE_CLR;

    // master: bus node plus layer controller side; slave: the receive buffer
    modport master (
        output RX_ADDR, RX_DATA, RX_REQ, RX_PEND, MSG_READY, OVERSIZE_CLR,
        input  RX_ACK, MSG_ADDR, MSG_DATA, MSG_LAST, MSG_VALID, OVERSIZE
    );

    modport slave (
        input  RX_ADDR, RX_DATA, RX_REQ, RX_PEND, MSG_READY, OVERSIZE_CLR,
        output RX_ACK, MSG_ADDR, MSG_DATA, MSG_LAST, MSG_VALID, OVERSIZE
    );
endinterface

// File: rtl/ulpb_rx_buffer.sv
// rtl/ulpb_rx_buffer.sv - ULPB receive FIFO releasing only complete messages, dropping oversize ones
module ulpb_rx_buffer #(
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic             CLKIN,
    input  logic             RESET,
    ulpb_rx_buffer_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef enum logic {IDLE, ACK_HI} state_t;

    state_t                state, state_nxt;
    logic                  req_meta, req_s;
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [CNT_W-1:0]      count, msg_cnt;
    logic                  discard, oversize;
    logic                  full, overflow, wr_en, wr_last, pop, head_last, discard_clr;

    logic [ADDR_WIDTH-1:0] mem_addr [DEPTH];
    logic [DATA_WIDTH-1:0] mem_data [DEPTH];
    logic                  mem_last [DEPTH];

    always_ff @(posedge CLKIN) begin
        if (RESET) begin
            req_meta <= 1'b0;
            req_s    <= 1'b0;
        end else begin
            req_meta <= bus.RX_REQ;
            req_s    <= req_meta;
        end
    end

    assign full      = (count == FULL_CNT);
    // A full FIFO with no complete message inside can never drain: flush it.
    assign overflow  = full && (msg_cnt == '0);
    assign wr_last   = ~bus.RX_PEND;
    assign head_last = mem_last[rd_ptr];
    assign pop       = (msg_cnt != '0) && bus.MSG_READY;

    always_comb begin
        state_nxt   = state;
        wr_en       = 1'b0;
        discard_clr = 1'b0;
        case (state)
            IDLE: begin
                if (req_s) begin
                    if (discard) begin
                        discard_clr = ~bus.RX_PEND;
                        state_nxt   = ACK_HI;
                    end else if (!full) begin
                        wr_en     = 1'b1;
                        state_nxt = ACK_HI;
                    end
                end
            end
            ACK_HI: begin
                if (!req_s) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLKIN) begin
        if (RESET) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge CLKIN) begin
        if (RESET || overflow) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            msg_cnt <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)   rd_ptr <= rd_ptr + PTR_W'(1);
            count   <= count + CNT_W'(wr_en) - CNT_W'(pop);
            msg_cnt <= msg_cnt + CNT_W'(wr_en & wr_last) - CNT_W'(pop & head_last);
        end
    end

    always_ff @(posedge CLKIN) begin
        if (RESET) begin
            discard  <= 1'b0;
            oversize <= 1'b0;
        end else begin
            if (overflow)         discard <= 1'b1;
            else if (discard_clr) discard <= 1'b0;
            if (overflow)              oversize <= 1'b1;
            else if (bus.OVERSIZE_CLR) oversize <= 1'b0;
        end
    end

    always_ff @(posedge CLKIN) begin
        if (wr_en) begin
            mem_addr[wr_ptr] <= bus.RX_ADDR;
            mem_data[wr_ptr] <= bus.RX_DATA;
            mem_last[wr_ptr] <= wr_last;
        end
    end

    assign bus.RX_ACK    = (state == ACK_HI);
    assign bus.MSG_ADDR  = mem_addr[rd_ptr];
    assign bus.MSG_DATA  = mem_data[rd_ptr];
    assign bus.MSG_LAST  = head_last;
    assign bus.MSG_VALID = (msg_cnt != '0);
    assign bus.OVERSIZE  = oversize;
endmodule

// File: tb/tb_ulpb_rx_buffer.sv
// tb/tb_ulpb_rx_buffer.sv - directed self-checking bench for ulpb_rx_buffer
module tb_ulpb_rx_buffer;
    logic CLKIN = 1'b0;
    logic RESET;
    int   n_checks = 0;
    int   n_errors = 0;
    logic [31:0] exp_q[$];

    always #5 CLKIN = ~CLKIN;

    ulpb_rx_buffer_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) bus ();

    ulpb_rx_buffer #(.DEPTH(8), .ADDR_WIDTH(8), .DATA_WIDTH(32)) dut (
        .CLKIN (CLKIN),
        .RESET (RESET),
        .bus   (bus)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLKIN);
        #1;
    endtask

    task automatic start_word(input logic [7:0] a, input logic [31:0] d, input logic pend);
        bus.RX_ADDR = a;
        bus.RX_DATA = d;
        bus.RX_PEND = pend;
        bus.RX_REQ  = 1'b1;
    endtask

    task automatic wait_ack(input int limit, output int edges);
        edges = 0;
        while (edges < limit && bus.RX_ACK !== 1'b1) begin
            step();
            edges++;
        end
    endtask

    task automatic end_word();
        int e;
        bus.RX_REQ = 1'b0;
        e = 0;
        while (e < 10 && bus.RX_ACK !== 1'b0) begin
            step();
            e++;
        end
        check_eq("ack_drop", bus.RX_ACK, 1'b0);
    endtask

    task automatic send_word(input logic [7:0] a, input logic [31:0] d, input logic pend);
        int e;
        start_word(a, d, pend);
        wait_ack(20, e);
        check_eq("ack_rise", bus.RX_ACK, 1'b1);
        end_word();
    endtask

    initial begin
        int e;
        logic any_valid;
        #100_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e;
        logic any_valid;
        RESET = 1'b1;
        bus.RX_ADDR = '0; bus.RX_DATA = '0; bus.RX_REQ = 1'b0; bus.RX_PEND = 1'b0;
        bus.MSG_READY = 1'b0; bus.OVERSIZE_CLR = 1'b0;
        repeat (3) step();
        RESET = 1'b0;
        step();
        check_eq("rst_ack", bus.RX_ACK, 1'b0);
        check_eq("rst_valid", bus.MSG_VALID, 1'b0);
        check_eq("rst_oversize", bus.OVERSIZE, 1'b0);

        // Single-word message, layer always ready
        bus.MSG_READY = 1'b1;
        start_word(8'hEF, 32'hDEADBEEF, 1'b0);
        wait_ack(20, e);
        check_eq("single_ack_lat", e, 3);
        check_eq("single_valid", bus.MSG_VALID, 1'b1);
        check_eq("single_addr", bus.MSG_ADDR, 8'hEF);
        check_eq("single_data", bus.MSG_DATA, 32'hDEADBEEF);
        check_eq("single_last", bus.MSG_LAST, 1'b1);
        step();
        check_eq("single_valid_drop", bus.MSG_VALID, 1'b0);
        check_eq("single_count", dut.count, 0);
        end_word();

        // Three-word message held until complete
        bus.MSG_READY = 1'b0;
        send_word(8'h10, 32'hA0000000, 1'b1);
        check_eq("m3_valid_w1", bus.MSG_VALID, 1'b0);
        send_word(8'h11, 32'hA0000001, 1'b1);
        check_eq("m3_valid_w2", bus.MSG_VALID, 1'b0);
        send_word(8'h12, 32'hA0000002, 1'b0);
        check_eq("m3_valid_w3", bus.MSG_VALID, 1'b1);
        bus.MSG_READY = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check_eq("m3_addr", bus.MSG_ADDR, 8'h10 + i);
            check_eq("m3_data", bus.MSG_DATA, 32'hA0000000 + i);
            check_eq("m3_last", bus.MSG_LAST, (i == 2) ? 1'b1 : 1'b0);
            step();
        end
        bus.MSG_READY = 1'b0;
        check_eq("m3_empty", bus.MSG_VALID, 1'b0);

        // Back-pressure: two 4-word messages fill the FIFO, ninth word waits for a pop
        for (int i = 0; i < 8; i++) begin
            send_word(8'h20 + i, 32'hB0000000 + i, (i % 4 == 3) ? 1'b0 : 1'b1);
            exp_q.push_back(32'hB0000000 + i);
        end
        check_eq("bp_count_full", dut.count, 8);
        start_word(8'h28, 32'hB0000008, 1'b0);
        exp_q.push_back(32'hB0000008);
        wait_ack(15, e);
        check_eq("bp_noack", bus.RX_ACK, 1'b0);
        check_eq("bp_head", bus.MSG_DATA, exp_q.pop_front());
        bus.MSG_READY = 1'b1;
        step();
        bus.MSG_READY = 1'b0;
        wait_ack(10, e);
        check_eq("bp_ack_lat", e, 1);
        check_eq("bp_count_refill", dut.count, 8);
        end_word();
        bus.MSG_READY = 1'b1;
        while (exp_q.size() > 0) begin
            check_eq("bp_drain", bus.MSG_DATA, exp_q.pop_front());
            step();
        end
        bus.MSG_READY = 1'b0;
        check_eq("bp_drained", dut.count, 0);
        check_eq("bp_drained_valid", bus.MSG_VALID, 1'b0);

        // Oversize: 10-word message is acked in full but dropped
        any_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            send_word(8'h30 + i, 32'hD0000000 + i, (i == 9) ? 1'b0 : 1'b1);
            if (bus.MSG_VALID) any_valid = 1'b1;
        end
        check_eq("ovs_flag", bus.OVERSIZE, 1'b1);
        check_eq("ovs_no_valid", any_valid, 1'b0);
        check_eq("ovs_count", dut.count, 0);
        send_word(8'h5A, 32'h12345678, 1'b0);
        check_eq("ovs_next_valid", bus.MSG_VALID, 1'b1);
        check_eq("ovs_next_addr", bus.MSG_ADDR, 8'h5A);
        check_eq("ovs_next_data", bus.MSG_DATA, 32'h12345678);
        check_eq("ovs_next_last", bus.MSG_LAST, 1'b1);
        bus.MSG_READY = 1'b1;
        step();
        bus.MSG_READY = 1'b0;
        check_eq("ovs_next_popped", bus.MSG_VALID, 1'b0);
        check_eq("ovs_sticky", bus.OVERSIZE, 1'b1);
        bus.OVERSIZE_CLR = 1'b1;
        step();
        bus.OVERSIZE_CLR = 1'b0;
        check_eq("ovs_clr", bus.OVERSIZE, 1'b0);

        // Simultaneous write and pop at count 4, pointers wrap
        for (int i = 0; i < 4; i++) begin
            send_word(8'h40 + i, 32'hC0000000 + i, 1'b0);
            exp_q.push_back(32'hC0000000 + i);
        end
        check_eq("sim_count_init", dut.count, 4);
        for (int i = 4; i < 10; i++) begin
            start_word(8'h40 + i, 32'hC0000000 + i, 1'b0);
            exp_q.push_back(32'hC0000000 + i);
            step();
            step();
            check_eq("sim_head", bus.MSG_DATA, exp_q.pop_front());
            bus.MSG_READY = 1'b1;
            step();
            bus.MSG_READY = 1'b0;
            check_eq("sim_ack", bus.RX_ACK, 1'b1);
            check_eq("sim_count", dut.count, 4);
            check_eq("sim_msg_cnt", dut.msg_cnt, 4);
            end_word();
        end
        bus.MSG_READY = 1'b1;
        while (exp_q.size() > 0) begin
            check_eq("sim_drain_data", bus.MSG_DATA, exp_q.pop_front());
            check_eq("sim_drain_last", bus.MSG_LAST, 1'b1);
            step();
        end
        bus.MSG_READY = 1'b0;
        check_eq("sim_empty", bus.MSG_VALID, 1'b0);

        // Reset in the middle of a handshake with two entries stored
        send_word(8'h11, 32'h00001111, 1'b1);
        start_word(8'h22, 32'h00002222, 1'b0);
        wait_ack(20, e);
        check_eq("rstm_pre_ack", bus.RX_ACK, 1'b1);
        check_eq("rstm_pre_count", dut.count, 2);
        RESET = 1'b1;
        step();
        check_eq("rstm_ack", bus.RX_ACK, 1'b0);
        check_eq("rstm_valid", bus.MSG_VALID, 1'b0);
        check_eq("rstm_count", dut.count, 0);
        check_eq("rstm_oversize", bus.OVERSIZE, 1'b0);
        RESET = 1'b0;
        wait_ack(10, e);
        check_eq("rstm_reack_lat", e, 3);
        check_eq("rstm_recount", dut.count, 1);
        check_eq("rstm_revalid", bus.MSG_VALID, 1'b1);
        check_eq("rstm_redata", bus.MSG_DATA, 32'h00002222);
        end_word();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
